// File: rtl/slow_window_pkg.sv
// Shared definitions for the slow-access window: state encoding, prescaler
// default and the device bit positions in the select/flag vectors.
package slow_window_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int TICKDIV_DEFAULT = 16;

    localparam int NDEV = 6;
    localparam int IACK = 0;
    localparam int VIA  = 1;
    localparam int IWM  = 2;
    localparam int SCC  = 3;
    localparam int SCSI = 4;
    localparam int SND  = 5;

endpackage

// File: rtl/slow_tick_div.sv
// Free-running prescaler producing a one-cycle Tick every TICKDIV clocks.
module slow_tick_div
    import slow_window_pkg::*;
#(
    parameter int TICKDIV = TICKDIV_DEFAULT,
    parameter int TICKW   = 4
) (
    input  logic CLK,
    input  logic nPOR,
    output logic Tick
);

    localparam logic [TICKW-1:0] LAST = TICKW'(TICKDIV - 1);

    logic [TICKW-1:0] cntQ;
    logic [TICKW-1:0] cntD;

    assign Tick = (cntQ == LAST);
    assign cntD = Tick ? '0 : cntQ + TICKW'(1);

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

endmodule

// File: rtl/slow_window.sv
// Holds the slow-mode request for the duration of an access to a slow
// peripheral plus a programmable number of coarse ticks afterwards.
module slow_window
    import slow_window_pkg::*;
#(
    parameter int TICKDIV = TICKDIV_DEFAULT,
    parameter int TICKW   = 4
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCSWR,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       Slow,
    output logic       ClockGate,
    output logic [3:0] HoldCnt
);

    logic [NDEV-1:0] selV;
    logic [NDEV-1:0] flagV;
    logic            tick;
    logic            startStrobe;
    logic            endStrobe;
    logic            hit;

    logic            bactQ;
    state_e          stateQ, stateD;
    logic [3:0]      holdCntQ, holdCntD;
    logic            gateEnQ, gateEnD;
    logic            slowQ;
    logic            gateQ;

    assign selV[IACK]  = IACKCS;
    assign selV[VIA]   = VIACS;
    assign selV[IWM]   = IWMCS;
    assign selV[SCC]   = SCCCS;
    assign selV[SCSI]  = SCSICS;
    assign selV[SND]   = SndCSWR;
    assign flagV[IACK] = SlowIACK;
    assign flagV[VIA]  = SlowVIA;
    assign flagV[IWM]  = SlowIWM;
    assign flagV[SCC]  = SlowSCC;
    assign flagV[SCSI] = SlowSCSI;
    assign flagV[SND]  = SlowSnd;

    assign startStrobe = BACT && !bactQ;
    assign endStrobe   = !BACT && bactQ;
    assign hit         = startStrobe && |(selV & flagV);

    slow_tick_div #(
        .TICKDIV(TICKDIV),
        .TICKW  (TICKW)
    ) uTickDiv (
        .CLK (CLK),
        .nPOR(nPOR),
        .Tick(tick)
    );

    // A hit in HOLD takes priority over a coincident tick, so no decrement.
    always_comb begin
        stateD   = stateQ;
        holdCntD = holdCntQ;
        gateEnD  = gateEnQ;
        case (stateQ)
            IDLE: begin
                if (hit) begin
                    stateD  = ACCESS;
                    gateEnD = SlowClockGate;
                end
            end
            ACCESS: begin
                if (endStrobe) begin
                    holdCntD = SlowTimeout;
                    stateD   = (SlowTimeout != 4'd0) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (hit) begin
                    stateD  = ACCESS;
                    gateEnD = SlowClockGate;
                end else if (tick) begin
                    if (holdCntQ == 4'd1) begin
                        stateD   = IDLE;
                        holdCntD = 4'd0;
                    end else begin
                        holdCntD = holdCntQ - 4'd1;
                    end
                end
            end
            default: begin
                stateD   = IDLE;
                holdCntD = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            bactQ    <= 1'b0;
            stateQ   <= IDLE;
            holdCntQ <= 4'd0;
            gateEnQ  <= 1'b0;
            slowQ    <= 1'b0;
            gateQ    <= 1'b0;
        end else begin
            bactQ    <= BACT;
            stateQ   <= stateD;
            holdCntQ <= holdCntD;
            gateEnQ  <= gateEnD;
            slowQ    <= (stateQ != IDLE);
            gateQ    <= (stateQ != IDLE) && gateEnQ;
        end
    end

    assign Slow      = slowQ;
    assign ClockGate = gateQ;
    assign HoldCnt   = holdCntQ;

endmodule

// File: tb/tb_slow_window.sv
// Randomised scoreboard bench for slow_window against a cycle-level
// behavioural model of the access/hold-off window.
module tb_slow_window;
    import slow_window_pkg::*;

    localparam int TICKDIV = 16;

    logic       CLK = 1'b0;
    logic       nPOR = 1'b0;
    logic       BACT = 1'b0;
    logic [5:0] sel = '0;
    logic [5:0] flag = '0;
    logic       gateReq = 1'b0;
    logic [3:0] timeout = '0;
    logic       Slow;
    logic       ClockGate;
    logic [3:0] HoldCnt;

    logic       sRstN = 1'b0;
    logic       sBact = 1'b0;
    logic [5:0] sSel = '0;
    logic [5:0] sFlag = '0;
    logic       sGate = 1'b0;
    logic [3:0] sTimeout = '0;

    bit mBusy, mGate, mPrevBact;
    int mRemaining, mPhase;

    typedef struct {
        logic       slow;
        logic       gate;
        logic [3:0] hold;
    } exp_t;
    exp_t expQ[$];

    int checks = 0;
    int passes = 0;
    bit done = 0;

    always #5 CLK = ~CLK;

    slow_window #(.TICKDIV(TICKDIV), .TICKW(4)) dut (
        .CLK          (CLK),
        .nPOR         (nPOR),
        .BACT         (BACT),
        .IACKCS       (sel[IACK]),
        .VIACS        (sel[VIA]),
        .IWMCS        (sel[IWM]),
        .SCCCS        (sel[SCC]),
        .SCSICS       (sel[SCSI]),
        .SndCSWR      (sel[SND]),
        .SlowIACK     (flag[IACK]),
        .SlowVIA      (flag[VIA]),
        .SlowIWM      (flag[IWM]),
        .SlowSCC      (flag[SCC]),
        .SlowSCSI     (flag[SCSI]),
        .SlowSnd      (flag[SND]),
        .SlowClockGate(gateReq),
        .SlowTimeout  (timeout),
        .Slow         (Slow),
        .ClockGate    (ClockGate),
        .HoldCnt      (HoldCnt)
    );

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic failWait(input string name);
        checks++;
        $display("[TB] FAIL %s: wait condition never reached at %0t", name, $time);
    endtask

    function automatic void modelReset();
        mBusy = 0; mGate = 0; mPrevBact = 0; mRemaining = 0; mPhase = 0;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict what the
    // outputs will show after the next rising edge, and queue it.
    task automatic applyStimulus();
        exp_t e;
        bit start, endS, hit, tick, active;
        @(negedge CLK);
        nPOR = sRstN; BACT = sBact; sel = sSel; flag = sFlag;
        gateReq = sGate; timeout = sTimeout;
        if (!nPOR) begin
            modelReset();
            e.slow = 0; e.gate = 0; e.hold = 0;
        end else begin
            start  = BACT && !mPrevBact;
            endS   = !BACT && mPrevBact;
            hit    = start && ((sel & flag) != 6'd0);
            tick   = (mPhase == TICKDIV - 1);
            active = mBusy || (mRemaining > 0);
            e.slow = active;
            e.gate = active && mGate;
            if (mBusy) begin
                if (endS) begin
                    mBusy = 0;
                    mRemaining = int'(timeout);
                end
            end else if (hit) begin
                mBusy = 1;
                mGate = gateReq;
            end else if (mRemaining > 0 && tick) begin
                mRemaining--;
            end
            e.hold = 4'(mRemaining);
            mPrevBact = BACT;
            mPhase = (mPhase + 1) % TICKDIV;
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        sBact = 0;
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic access(input int dev, input logic [5:0] flags, input logic g,
                          input logic [3:0] t, input int highCycles);
        sSel = 6'd1 << dev; sFlag = flags; sGate = g; sTimeout = t; sBact = 1;
        for (int i = 0; i < highCycles; i++) applyStimulus();
        sBact = 0;
        applyStimulus();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("Slow", {3'b0, Slow}, {3'b0, e.slow});
                checkOutput("ClockGate", {3'b0, ClockGate}, {3'b0, e.gate});
                checkOutput("HoldCnt", HoldCnt, e.hold);
            end
        end
    end

    initial begin : stimulus
        bit found;
        modelReset();

        // Access attempts while reset is held must not raise Slow.
        sRstN = 0; sSel = 6'd1 << VIA; sFlag = 6'd1 << VIA;
        idle(2);
        sBact = 1; applyStimulus(); applyStimulus();
        idle(2);
        sRstN = 1;
        idle(3);

        access(VIA, 6'd1 << VIA, 1'b0, 4'd3, 4);
        idle(60);

        access(SCC, 6'd1 << IWM, 1'b1, 4'd3, 3);
        idle(10);

        access(IWM, 6'd1 << IWM, 1'b1, 4'd0, 3);
        idle(5);

        // Re-hit on a tick cycle while two ticks remain.
        access(VIA, 6'd1 << VIA, 1'b0, 4'd3, 2);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!mBusy && mRemaining == 2 && mPhase == TICKDIV - 1) found = 1;
            else applyStimulus();
        end
        if (!found) failWait("rehit_on_tick");
        access(VIA, 6'd1 << VIA, 1'b1, 4'd5, 2);
        idle(100);

        // Asynchronous reset in the middle of a hold-off.
        access(VIA, 6'd1 << VIA, 1'b1, 4'd6, 2);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!mBusy && mRemaining == 4) found = 1;
            else applyStimulus();
        end
        if (!found) failWait("hold_at_4");
        @(negedge CLK);
        #2 nPOR = 0;
        #1;
        checkOutput("async_Slow", {3'b0, Slow}, 4'd0);
        checkOutput("async_ClockGate", {3'b0, ClockGate}, 4'd0);
        checkOutput("async_HoldCnt", HoldCnt, 4'd0);
        modelReset();
        sRstN = 0;
        idle(3);
        sRstN = 1;
        idle(20);

        // Random traffic; flags and timeout wander while BACT is high.
        for (int b = 0; b < 150; b++) begin
            int hi, lo;
            sSel = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
            sFlag = 6'($urandom_range(0, 63));
            sGate = 1'($urandom_range(0, 1));
            sTimeout = 4'($urandom_range(0, 4));
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 40);
            sBact = 1;
            for (int i = 0; i < hi; i++) begin
                applyStimulus();
                sFlag = 6'($urandom_range(0, 63));
                sGate = 1'($urandom_range(0, 1));
                sTimeout = 4'($urandom_range(0, 4));
            end
            idle(lo);
        end

        idle(2);
        @(posedge CLK);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
